ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  in  1  single clock; all state SHALL update on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: imem_req  out  1  read request to instruction memory.
REQ-005 Port: imem_addr  out  32  request address, word-aligned.
REQ-006 Port: imem_gnt  in  1  memory accepted request this cycle.
REQ-007 Port: imem_rvalid  in  1  read data valid, at least one cycle after gnt.
REQ-008 Port: imem_rdata  in  32  instruction word.
REQ-009 Port: idata  out  32  instruction word to decoder.
REQ-010 Port: ipc  out  32  address of idata.
REQ-011 Port: ivalid  out  1  idata/ipc valid.
REQ-012 Port: iready  in  1  decoder consumes head when ivalid&&iready.
REQ-013 Port: redirect  in  1  branch/jump/trap redirect strobe.
REQ-014 Port: redirect_pc  in  32  redirect target.
REQ-015 Port: fetch_misaligned  out  1  sticky misaligned-target flag.

Function
REQ-016 FSM states IDLE, REQ, WAIT; at most one outstanding memory request.
REQ-017 IDLE->REQ when buffer occupancy + outstanding < 2 and fetch_misaligned=0.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc held stable until imem_gnt; on gnt -> WAIT, fetch_pc <= fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 WAIT: on imem_rvalid push {imem_rdata, request addr} into 2-entry FIFO; -> REQ if space remains after push, else IDLE.
REQ-020 imem_rvalid outside WAIT SHALL be ignored.
REQ-021 ivalid = FIFO non-empty; idata/ipc = FIFO head; pop on ivalid&&iready; push and pop in same cycle allowed.
REQ-022 Latency: pushed word visible on ivalid the cycle after imem_rvalid.
REQ-023 redirect has highest priority: FIFO flushed (ivalid=0 next cycle), simultaneous pop ignored, fetch_pc <= redirect_pc.
REQ-024 redirect in REQ without gnt: request withdrawn, next cycle imem_addr=redirect_pc.
REQ-025 redirect in WAIT, or in REQ coincident with gnt: drop flag set, matching imem_rvalid discarded, then -> REQ at redirect_pc.
REQ-026 redirect_pc[1:0]!=0: fetch_misaligned=1, no requests issued, FIFO empty; cleared by next aligned redirect.
REQ-027 Outstanding response still dropped per REQ-025 while misaligned.

Reset
REQ-028 rst asserted: state IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, idata=0, ipc=0, ivalid=0, fetch_misaligned=0, drop flag=0, immediately without clock.
REQ-029 Reset mid-WAIT SHALL abandon the transaction; a stray later imem_rvalid is ignored per REQ-020.
REQ-030 First imem_req SHALL assert on the first rising edge after rst deasserts.

Structure
REQ-031 Fetch FSM state enum, XLEN=32, INST_NOP=32'h0000_0013 SHALL live in the shared riscv_def package.
REQ-032 FIFO SHALL be sub-module ifetch_fifo (2-entry, data+pc, flush input).

Verification
REQ-033 Reset release, zero-wait memory returning 32'h00A4_85B3 at 0 -> ivalid=1, idata=32'h00A485B3 (add x11,x9,x10), ipc=0, next imem_addr=4.
REQ-034 iready=0 -> words at 0 and 4 buffered, imem_req stays 0; iready=1 -> fetch resumes at 8, decoder sees 0,4,8 in order.
REQ-035 redirect_pc=32'h100 while fetch of 8 in WAIT -> response for 8 discarded, next imem_addr=32'h100, ipc never equals 8.
REQ-036 redirect_pc=32'h102 -> fetch_misaligned=1, imem_req=0, ivalid=0; redirect_pc=32'h200 -> flag clears, imem_addr=32'h200.
REQ-037 redirect_pc=32'hFFFF_FFFC -> after gnt next imem_addr=0.
REQ-038 rst pulsed asynchronously mid-WAIT, then rvalid with 32'h40A4_85B3 -> all outputs reset values, word never appears on idata.

Source files
------------

// File: rtl/riscv_def.sv
// Shared core definitions: datapath width, canonical NOP and the fetch FSM encoding.
package riscv_def;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry instruction buffer holding {word, pc}; entry 0 is always the head.
module ifetch_fifo
  import riscv_def::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_data_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] head_data_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [1:0]      count_o
);

  logic [XLEN-1:0] data_q [2];
  logic [XLEN-1:0] data_d [2];
  logic [XLEN-1:0] pc_q   [2];
  logic [XLEN-1:0] pc_d   [2];
  logic [1:0]      count_q, count_d;
  logic [1:0]      wr_slot;
  logic            do_pop, do_push;

  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    count_d = count_q;
    wr_slot = count_q;
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      do_pop = pop_i && (count_q != 2'd0);
      // a pop shifts entry 1 down, so the write slot moves down with it
      if (do_pop) begin
        data_d[0] = data_q[1];
        pc_d[0]   = pc_q[1];
        wr_slot   = count_q - 2'd1;
      end
      do_push = push_i && (wr_slot != 2'd2);
      if (do_push) begin
        data_d[wr_slot[0]] = push_data_i;
        pc_d[wr_slot[0]]   = push_pc_i;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '{default: '0};
      pc_q    <= '{default: '0};
      count_q <= 2'd0;
    end else begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign valid_o     = (count_q != 2'd0);
  assign head_data_o = data_q[0];
  assign head_pc_o   = pc_q[0];
  assign count_o     = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: single-outstanding memory requester feeding a 2-entry buffer,
// with redirect flush, late-response dropping and misaligned-target lockout.
module ifetch
  import riscv_def::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] idata,
  output logic [XLEN-1:0] ipc,
  output logic            ivalid,
  input  logic            iready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic            mis_q, mis_d;
  logic            fifo_push, fifo_pop, room_after_push, target_aligned;
  logic [1:0]      fifo_count;

  assign target_aligned  = (redirect_pc[1:0] == 2'b00);
  assign fifo_pop        = ivalid && iready && !redirect;
  assign room_after_push = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && fifo_pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    mis_d      = mis_q;
    fifo_push  = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if ((fifo_count != 2'd2) && !mis_q) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (imem_gnt) begin
          state_d    = FETCH_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = pc_incr(fetch_pc_q);
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = mis_q ? FETCH_IDLE : FETCH_REQ;
          end else begin
            fifo_push = 1'b1;
            state_d   = room_after_push ? FETCH_REQ : FETCH_IDLE;
          end
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    // redirect overrides everything; an accepted-but-unanswered request must still be drained
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      mis_d      = !target_aligned;
      fifo_push  = 1'b0;
      if (((state_q == FETCH_WAIT) && !imem_rvalid) || ((state_q == FETCH_REQ) && imem_gnt)) begin
        drop_d  = 1'b1;
        state_d = FETCH_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = target_aligned ? FETCH_REQ : FETCH_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_req         = (state_q == FETCH_REQ);
  assign imem_addr        = fetch_pc_q;
  assign fetch_misaligned = mis_q;

  ifetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_data_i(imem_rdata),
    .push_pc_i  (req_pc_q),
    .pop_i      (fifo_pop),
    .flush_i    (redirect),
    .valid_o    (ivalid),
    .head_data_o(idata),
    .head_pc_o  (ipc),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: memory responder, stream-level reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] idata;
  logic [31:0] ipc;
  logic        ivalid;
  logic        iready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .idata           (idata),
    .ipc             (ipc),
    .ivalid          (ivalid),
    .iready          (iready),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model of the architectural stream
  logic [31:0] exp_pc, exp_fetch, prev_addr;
  bit          m_mis, expect_empty, prev_stall;
  logic [31:0] consumed_q[$];
  int          seen8, seen_stray;

  // memory responder state
  bit          pend, stray;
  logic [31:0] pend_addr;
  int          pend_dly, lat, gnt_lag, req_age;
  localparam logic [31:0] STRAY_WORD = 32'h40A4_85B3;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00A4_85B3 : (a ^ 32'h1357_9BDF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // memory: grants after gnt_lag waiting cycles, answers lat cycles after the grant cycle
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (stray) begin
        imem_rvalid = 1'b1; imem_rdata = STRAY_WORD; stray = 1'b0;
      end else if (pend) begin
        if (pend_dly == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pend = 1'b0;
        end else pend_dly--;
      end
      imem_gnt = 1'b0;
      if (!rst && imem_req && !pend) begin
        if (req_age >= gnt_lag) begin
          imem_gnt = 1'b1; pend = 1'b1; pend_addr = imem_addr; pend_dly = lat; req_age = 0;
        end else req_age++;
      end else req_age = 0;
    end
  end

  // per-cycle comparison just before each rising edge
  initial begin
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ivalid", 32'(ivalid), 32'd0);
        chk("rst_mis", 32'(fetch_misaligned), 32'd0);
      end else begin
        chk("mis_flag", 32'(fetch_misaligned), 32'(m_mis));
        if (expect_empty) begin
          chk("flush_empty", 32'(ivalid), 32'd0);
          expect_empty = 1'b0;
        end
        if (m_mis) begin
          chk("mis_no_req", 32'(imem_req), 32'd0);
          chk("mis_no_valid", 32'(ivalid), 32'd0);
        end
        if (prev_stall) begin
          chk("req_hold", 32'(imem_req), 32'd1);
          chk("req_hold_addr", imem_addr, prev_addr);
        end
        if (ivalid) begin
          chk("head_pc", ipc, exp_pc);
          chk("head_data", idata, mem_word(exp_pc));
          if (ipc == 32'h8) seen8++;
          if (idata == STRAY_WORD) seen_stray++;
        end
        if (ivalid && iready && !redirect) begin
          consumed_q.push_back(ipc);
          exp_pc = exp_pc + 32'd4;
        end
        if (imem_req && imem_gnt) begin
          chk("fetch_addr", imem_addr, exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect) begin
          exp_fetch    = redirect_pc;
          exp_pc       = redirect_pc;
          m_mis        = (redirect_pc[1:0] != 2'b00);
          expect_empty = 1'b1;
        end
        prev_stall = imem_req && !imem_gnt && !redirect;
        prev_addr  = imem_addr;
      end
    end
  end

  // asynchronous reset pulse between clock edges; outputs must reset without a clock
  task automatic pulse_reset(input bit with_stray);
    @(negedge clk); #2;
    rst = 1'b1;
    exp_pc = 32'h0; exp_fetch = 32'h0; m_mis = 1'b0; expect_empty = 1'b1; prev_stall = 1'b0;
    pend = 1'b0; req_age = 0; stray = with_stray;
    consumed_q.delete(); seen_stray = 0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_ivalid", 32'(ivalid), 32'd0);
    chk("arst_idata", idata, 32'h0);
    chk("arst_ipc", ipc, 32'h0);
    chk("arst_mis", 32'(fetch_misaligned), 32'd0);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(negedge clk); #2;
    redirect = 1'b1; redirect_pc = pc; consumed_q.delete(); seen8 = 0;
    @(negedge clk); #2;
    redirect = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; iready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    lat = 0; gnt_lag = 0; pend = 1'b0; stray = 1'b0; req_age = 0; pend_dly = 0; pend_addr = 32'h0;
    exp_pc = 32'h0; exp_fetch = 32'h0; m_mis = 1'b0; expect_empty = 1'b0; prev_stall = 1'b0;
    prev_addr = 32'h0; seen8 = 0; seen_stray = 0;
    repeat (3) @(negedge clk);

    // first request right after release, zero-wait memory
    pulse_reset(1'b0);
    @(negedge clk); #3;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    n = 0;
    while (!ivalid && n < 20) begin @(negedge clk); #3; n++; end
    chk("t1_ivalid", 32'(ivalid), 32'd1);
    chk("t1_idata", idata, 32'h00A4_85B3);
    chk("t1_ipc", ipc, 32'h0);
    chk("t1_next_addr", imem_addr, 32'h4);

    // backpressure fills the buffer and stops fetching
    iready = 1'b0;
    pulse_reset(1'b0);
    repeat (10) begin @(negedge clk); #3; end
    chk("t2_ivalid", 32'(ivalid), 32'd1);
    chk("t2_ipc", ipc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_no_req", 32'(imem_req), 32'd0);
      @(negedge clk); #3;
    end
    @(negedge clk); #2;
    iready = 1'b1;
    n = 0;
    while (consumed_q.size() < 3 && n < 40) begin @(negedge clk); #3; n++; end
    chk("t2_count", 32'(consumed_q.size() >= 3), 32'd1);
    if (consumed_q.size() >= 3) begin
      chk("t2_pc0", consumed_q[0], 32'h0);
      chk("t2_pc1", consumed_q[1], 32'h4);
      chk("t2_pc2", consumed_q[2], 32'h8);
    end

    // redirect while the fetch of 8 is waiting for its response
    lat = 2;
    pulse_reset(1'b0);
    n = 0;
    while (!(pend && pend_addr == 32'h8) && n < 40) begin @(negedge clk); #3; n++; end
    chk("t3_wait8", 32'(pend && pend_addr == 32'h8), 32'd1);
    do_redirect(32'h100);
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); #3; n++; end
    chk("t3_addr", imem_addr, 32'h100);
    n = 0;
    while (consumed_q.size() < 1 && n < 30) begin @(negedge clk); #3; n++; end
    chk("t3_first", (consumed_q.size() > 0) ? consumed_q[0] : 32'hDEAD_BEEF, 32'h100);
    chk("t3_no_pc8", 32'(seen8), 32'd0);

    // misaligned target locks fetch until an aligned redirect
    lat = 0;
    do_redirect(32'h102);
    chk("t4_mis", 32'(fetch_misaligned), 32'd1);
    chk("t4_req", 32'(imem_req), 32'd0);
    chk("t4_ivalid", 32'(ivalid), 32'd0);
    repeat (5) begin @(negedge clk); #3; chk("t4_idle", 32'(imem_req), 32'd0); end
    do_redirect(32'h200);
    chk("t4_clear", 32'(fetch_misaligned), 32'd0);
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); #3; n++; end
    chk("t4_addr", imem_addr, 32'h200);

    // redirect while a request is still waiting for its grant
    gnt_lag = 3;
    n = 0;
    while (!(imem_req && !imem_gnt) && n < 30) begin @(negedge clk); #3; n++; end
    chk("t4b_stall", 32'(imem_req && !imem_gnt), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h300; consumed_q.delete();
    @(negedge clk); #2;
    redirect = 1'b0;
    #1;
    chk("t4b_req", 32'(imem_req), 32'd1);
    chk("t4b_addr", imem_addr, 32'h300);

    // fetch address wraps past the top of the address space
    gnt_lag = 0;
    do_redirect(32'hFFFF_FFFC);
    n = 0;
    while (!(imem_req && imem_gnt && imem_addr == 32'hFFFF_FFFC) && n < 30) begin @(negedge clk); #3; n++; end
    chk("t5_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #3;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); #3; n++; end
    chk("t5_wrap", imem_addr, 32'h0);
    n = 0;
    while (consumed_q.size() < 2 && n < 30) begin @(negedge clk); #3; n++; end
    chk("t5_count", 32'(consumed_q.size() >= 2), 32'd1);
    if (consumed_q.size() >= 2) begin
      chk("t5_pc0", consumed_q[0], 32'hFFFF_FFFC);
      chk("t5_pc1", consumed_q[1], 32'h0);
    end

    // reset in the middle of a wait, then a stray late response
    lat = 3;
    n = 0;
    while (!(pend && !imem_req) && n < 30) begin @(negedge clk); #3; n++; end
    chk("t6_in_wait", 32'(pend && !imem_req), 32'd1);
    pulse_reset(1'b1);
    repeat (30) begin @(negedge clk); #3; end
    chk("t6_no_stray", 32'(seen_stray), 32'd0);
    chk("t6_first", (consumed_q.size() > 0) ? consumed_q[0] : 32'hDEAD_BEEF, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
